victim_buffer_rr: RTL and testbench

//  Parametrised fully-associative victim buffer between the I/D caches and memory.

---
 rtl/victim_buffer_rr.sv | 226 ++++++++++++++++++++++
 tb/tb_victim_buffer_rr.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_buffer_rr.sv
// Fully-associative victim buffer with dual combinational lookup, take/invalidate,
// round-robin replacement and a valid/ready writeback port for dirty evictees.
module victim_buffer_rr #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned TAG_W   = 14,
  parameter int unsigned DATA_W  = 64,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  // I-side lookup
  input  logic [TAG_W-1:0]  lk_i_addr,
  output logic              lk_i_hit,
  output logic [IDX_W-1:0]  lk_i_idx,
  output logic [DATA_W-1:0] lk_i_data,
  output logic              lk_i_dirty,
  // D-side lookup
  input  logic [TAG_W-1:0]  lk_d_addr,
  output logic              lk_d_hit,
  output logic [IDX_W-1:0]  lk_d_idx,
  output logic [DATA_W-1:0] lk_d_data,
  output logic              lk_d_dirty,
  // Insert
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [TAG_W-1:0]  ins_addr,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              ins_dirty,
  // Take (invalidate)
  input  logic              take_valid,
  input  logic [IDX_W-1:0]  take_idx,
  // Writeback
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TAG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [IDX_W:0]    occupancy
);

  typedef enum logic [0:0] {StIdle, StWb} state_e;

  state_e              st_q, st_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [ENTRIES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_d  [ENTRIES];
  logic [DATA_W-1:0]   data_q [ENTRIES];
  logic [DATA_W-1:0]   data_d [ENTRIES];
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W:0]      occ_q, occ_d;
  logic                wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]    wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [TAG_W-1:0]    hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_dirty_q, hold_dirty_d;

  logic                take_eff;
  logic [ENTRIES-1:0]  valid_t;
  logic                match_hit, free_hit;
  logic [IDX_W-1:0]    match_idx, free_idx;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_dirty;

  assign ins_ready = (st_q == StIdle);
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign occupancy = occ_q;

  // Lookups: descending scan so the lowest matching index wins.
  always_comb begin
    lk_i_hit   = 1'b0;
    lk_i_idx   = '0;
    lk_i_data  = '0;
    lk_i_dirty = 1'b0;
    lk_d_hit   = 1'b0;
    lk_d_idx   = '0;
    lk_d_data  = '0;
    lk_d_dirty = 1'b0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lk_i_addr)) begin
        lk_i_hit   = 1'b1;
        lk_i_idx   = IDX_W'(i);
        lk_i_data  = data_q[i];
        lk_i_dirty = dirty_q[i];
      end
      if (valid_q[i] && (tag_q[i] == lk_d_addr)) begin
        lk_d_hit   = 1'b1;
        lk_d_idx   = IDX_W'(i);
        lk_d_data  = data_q[i];
        lk_d_dirty = dirty_q[i];
      end
    end
  end

  // Take is applied first; insert decisions see the post-take valid vector.
  always_comb begin
    take_eff = take_valid && valid_q[take_idx];
    valid_t  = valid_q;
    if (take_eff) valid_t[take_idx] = 1'b0;

    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_t[i] && (tag_q[i] == ins_addr)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid_t[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    st_d         = st_q;
    valid_d      = valid_t;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    rr_d         = rr_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_dirty_d = hold_dirty_q;
    wr_en        = 1'b0;
    wr_idx       = '0;
    wr_tag       = ins_addr;
    wr_data      = ins_data;
    wr_dirty     = ins_dirty;

    if (take_eff) dirty_d[take_idx] = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (ins_valid) begin
          if (match_hit) begin
            wr_en    = 1'b1;
            wr_idx   = match_idx;
            wr_dirty = dirty_q[match_idx] | ins_dirty;
          end else if (free_hit) begin
            wr_en  = 1'b1;
            wr_idx = free_idx;
          end else if (!dirty_q[rr_q]) begin
            wr_en  = 1'b1;
            wr_idx = rr_q;
            rr_d   = rr_q + 1'b1;
          end else begin
            wb_valid_d   = 1'b1;
            wb_addr_d    = tag_q[rr_q];
            wb_data_d    = data_q[rr_q];
            hold_addr_d  = ins_addr;
            hold_data_d  = ins_data;
            hold_dirty_d = ins_dirty;
            st_d         = StWb;
          end
        end
      end
      StWb: begin
        // Evictee is already latched, so a take of slot rr_q does not disturb the writeback.
        if (wb_ready) begin
          wr_en      = 1'b1;
          wr_idx     = rr_q;
          wr_tag     = hold_addr_q;
          wr_data    = hold_data_q;
          wr_dirty   = hold_dirty_q;
          rr_d       = rr_q + 1'b1;
          wb_valid_d = 1'b0;
          st_d       = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase

    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = wr_dirty;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end

    occ_d = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      occ_d = occ_d + (IDX_W+1)'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      valid_q    <= '0;
      dirty_q    <= '0;
      rr_q       <= '0;
      occ_q      <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rr_q       <= rr_d;
      occ_q      <= occ_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Datapath storage is qualified by valid bits and needs no reset.
  always_ff @(posedge clk) begin
    tag_q        <= tag_d;
    data_q       <= data_d;
    wb_addr_q    <= wb_addr_d;
    wb_data_q    <= wb_data_d;
    hold_addr_q  <= hold_addr_d;
    hold_data_q  <= hold_data_d;
    hold_dirty_q <= hold_dirty_d;
  end

endmodule

// File: tb/tb_victim_buffer_rr.sv
// Bench for victim_buffer_rr: directed scenarios then randomized traffic, all
// outputs compared every cycle against a rule-level reference model.
module tb_victim_buffer_rr;

  localparam int ENTRIES = 4;
  localparam int TAG_W   = 14;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [TAG_W-1:0]  lk_i_addr, lk_d_addr;
  logic              lk_i_hit, lk_d_hit, lk_i_dirty, lk_d_dirty;
  logic [IDX_W-1:0]  lk_i_idx, lk_d_idx;
  logic [DATA_W-1:0] lk_i_data, lk_d_data;
  logic              ins_valid, ins_ready, ins_dirty;
  logic [TAG_W-1:0]  ins_addr;
  logic [DATA_W-1:0] ins_data;
  logic              take_valid;
  logic [IDX_W-1:0]  take_idx;
  logic              wb_valid, wb_ready;
  logic [TAG_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [IDX_W:0]    occupancy;

  always #5 clk = ~clk;

  victim_buffer_rr #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_i_addr  (lk_i_addr),
    .lk_i_hit   (lk_i_hit),
    .lk_i_idx   (lk_i_idx),
    .lk_i_data  (lk_i_data),
    .lk_i_dirty (lk_i_dirty),
    .lk_d_addr  (lk_d_addr),
    .lk_d_hit   (lk_d_hit),
    .lk_d_idx   (lk_d_idx),
    .lk_d_data  (lk_d_data),
    .lk_d_dirty (lk_d_dirty),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_addr   (ins_addr),
    .ins_data   (ins_data),
    .ins_dirty  (ins_dirty),
    .take_valid (take_valid),
    .take_idx   (take_idx),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .occupancy  (occupancy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit                m_valid [ENTRIES];
  bit                m_dirty [ENTRIES];
  logic [TAG_W-1:0]  m_tag   [ENTRIES];
  logic [DATA_W-1:0] m_data  [ENTRIES];
  int                m_rr;
  bit                m_wb;
  logic [TAG_W-1:0]  m_wb_addr, m_h_addr;
  logic [DATA_W-1:0] m_wb_data, m_h_data;
  bit                m_h_dirty;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_rr = 0;
    m_wb = 0;
  endtask

  task automatic model_lookup(input logic [TAG_W-1:0] a, output bit hit, output int idx,
                              output logic [DATA_W-1:0] d, output bit dt);
    hit = 0; idx = 0; d = '0; dt = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && m_valid[i] && m_tag[i] == a) begin
        hit = 1; idx = i; d = m_data[i]; dt = m_dirty[i];
      end
    end
  endtask

  task automatic compare_outputs();
    bit hit, dt;
    int idx, cnt;
    logic [DATA_W-1:0] d;
    check("ins_ready", ins_ready, !m_wb);
    check("wb_valid", wb_valid, m_wb);
    if (m_wb) begin
      check("wb_addr", wb_addr, m_wb_addr);
      check("wb_data", wb_data, m_wb_data);
    end
    cnt = 0;
    for (int i = 0; i < ENTRIES; i++) cnt += m_valid[i];
    check("occupancy", occupancy, cnt);
    model_lookup(lk_i_addr, hit, idx, d, dt);
    check("lk_i_hit", lk_i_hit, hit);
    check("lk_i_idx", lk_i_idx, idx);
    check("lk_i_data", lk_i_data, d);
    check("lk_i_dirty", lk_i_dirty, dt);
    model_lookup(lk_d_addr, hit, idx, d, dt);
    check("lk_d_hit", lk_d_hit, hit);
    check("lk_d_idx", lk_d_idx, idx);
    check("lk_d_data", lk_d_data, d);
    check("lk_d_dirty", lk_d_dirty, dt);
  endtask

  // Applies one clock of the behavioural rules to the model.
  task automatic model_step();
    int slot, free;
    if (rst) begin
      model_reset();
      return;
    end
    if (take_valid && m_valid[take_idx]) begin
      m_valid[take_idx] = 0;
      m_dirty[take_idx] = 0;
    end
    if (!m_wb) begin
      if (ins_valid) begin
        slot = -1;
        free = -1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
          if (m_valid[i] && m_tag[i] == ins_addr) slot = i;
          if (!m_valid[i]) free = i;
        end
        if (slot >= 0) begin
          m_data[slot]  = ins_data;
          m_dirty[slot] = m_dirty[slot] | ins_dirty;
        end else if (free >= 0) begin
          m_valid[free] = 1; m_tag[free] = ins_addr;
          m_data[free] = ins_data; m_dirty[free] = ins_dirty;
        end else if (!m_dirty[m_rr]) begin
          m_tag[m_rr] = ins_addr; m_data[m_rr] = ins_data; m_dirty[m_rr] = ins_dirty;
          m_rr = (m_rr + 1) % ENTRIES;
        end else begin
          m_wb = 1;
          m_wb_addr = m_tag[m_rr]; m_wb_data = m_data[m_rr];
          m_h_addr = ins_addr; m_h_data = ins_data; m_h_dirty = ins_dirty;
        end
      end
    end else if (wb_ready) begin
      m_valid[m_rr] = 1; m_tag[m_rr] = m_h_addr;
      m_data[m_rr] = m_h_data; m_dirty[m_rr] = m_h_dirty;
      m_rr = (m_rr + 1) % ENTRIES;
      m_wb = 0;
    end
  endtask

  // Inputs are set at the negedge; outputs compared 1 time unit later.
  task automatic cycle();
    #1;
    compare_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_insert(input logic [TAG_W-1:0] a, input bit dt);
    ins_valid = 1;
    ins_addr  = a;
    ins_data  = {$urandom, $urandom};
    ins_dirty = dt;
    cycle();
    ins_valid = 0;
  endtask

  logic [DATA_W-1:0] d5;

  initial begin
    rst = 1; ins_valid = 0; ins_addr = '0; ins_data = '0; ins_dirty = 0;
    take_valid = 0; take_idx = '0; wb_ready = 0;
    lk_i_addr = '0; lk_d_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset_occ", occupancy, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_ins_ready", ins_ready, 1);

    // Fill slots 0..3
    for (int t = 0; t < 4; t++) do_insert(TAG_W'(16 + t), 0);
    lk_i_addr = 14'h12;
    #1;
    check("t1_hit", lk_i_hit, 1);
    check("t1_idx", lk_i_idx, 2);
    check("t1_occ", occupancy, 4);

    // Full and clean: round-robin overwrite of slot 0
    do_insert(14'h20, 0);
    lk_i_addr = 14'h10;
    lk_d_addr = 14'h20;
    #1;
    check("t2_old_miss", lk_i_hit, 0);
    check("t2_new_hit", lk_d_hit, 1);
    check("t2_new_idx", lk_d_idx, 0);

    // Merge dirty into resident clean tag
    do_insert(14'h11, 1);
    d5 = ins_data;
    lk_d_addr = 14'h11;
    #1;
    check("t5_idx", lk_d_idx, 1);
    check("t5_dirty", lk_d_dirty, 1);
    check("t5_data", lk_d_data, d5);
    check("t5_occ", occupancy, 4);

    // rr_ptr=1 points at the dirty line: writeback with stalled memory
    do_insert(14'h30, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_wb_valid", wb_valid, 1);
      check("t3_wb_addr", wb_addr, 14'h11);
      check("t3_wb_data", wb_data, d5);
      check("t3_ins_ready", ins_ready, 0);
      cycle();
    end
    wb_ready = 1;
    cycle();
    wb_ready  = 0;
    lk_i_addr = 14'h30;
    #1;
    check("t3_ready_back", ins_ready, 1);
    check("t3_held_idx", lk_i_idx, 1);
    check("t3_wb_done", wb_valid, 0);

    // Take and insert in the same cycle while full
    take_valid = 1;
    take_idx   = 2'd1;
    do_insert(14'h40, 0);
    take_valid = 0;
    lk_i_addr  = 14'h40;
    lk_d_addr  = 14'h12;
    #1;
    check("t4_slot", lk_i_idx, 1);
    check("t4_occ", occupancy, 4);
    check("t4_no_evict", lk_d_hit, 1);

    // Reset in the middle of a writeback
    do_insert(14'h12, 1);
    do_insert(14'h50, 0);
    #1;
    check("t6_in_wb", wb_valid, 1);
    rst = 1;
    cycle();
    rst = 0;
    #1;
    check("t6_wb_valid", wb_valid, 0);
    check("t6_occ", occupancy, 0);
    check("t6_i_miss", lk_i_hit, 0);
    check("t6_d_miss", lk_d_hit, 0);

    // Randomized traffic with a small tag space to force hits and evictions
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!(m_wb && ins_valid)) begin
        ins_valid = $urandom_range(0, 1);
        ins_addr  = TAG_W'(16 + $urandom_range(0, 7));
        ins_data  = {$urandom, $urandom};
        ins_dirty = $urandom_range(0, 1);
      end
      take_valid = ($urandom_range(0, 3) == 0);
      take_idx   = IDX_W'($urandom_range(0, ENTRIES - 1));
      wb_ready   = ($urandom_range(0, 2) != 0);
      lk_i_addr  = TAG_W'(16 + $urandom_range(0, 7));
      lk_d_addr  = TAG_W'(16 + $urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
